// File: rtl/act_skew_feeder_if.sv
// ---------------------------------------------------------------------------
// act_skew_feeder_if
//
// Activation stream bus into the skew feeder. A vector moves when in_valid
// and in_ready are both high at a rising clock edge.
//
// Parameters:
//   ROWS  number of array rows / lanes carried by in_data
//   DW    activation width per lane
//
// Signals:
//   in_valid  source -> feeder   in_data / in_last are valid
//   in_ready  feeder -> source   feeder can take a vector this cycle
//   in_data   source -> feeder   lane r = in_data[r*DW +: DW]
//   in_last   source -> feeder   final vector of a tile
//
// Modports:
//   master  the activation source
//   slave   the feeder
// ---------------------------------------------------------------------------
interface act_skew_feeder_if #(
    parameter int ROWS = 2,
    parameter int DW   = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [ROWS*DW-1:0] in_data;
    logic               in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/act_skew_feeder.sv
// ---------------------------------------------------------------------------
// act_skew_feeder
//
// Activation feeder for the left column of a weight-stationary MAC array.
// Takes one unskewed activation vector per cycle and re-times it into a
// diagonal wavefront: lane r is delayed r cycles relative to lane 0. Bubbles
// are inserted on every cycle without an accept, and a one-cycle tile_done
// pulse marks the cycle in which the last element of a tile sits on lane
// ROWS-1.
//
// Build option:
//   SKEW_ZERO_FILL_EN  defined   -> bubble slots drive a_out lane = 0
//                      undefined -> bubble slots hold the previous a_out value
//                                   (downstream must gate on a_valid)
//
// Parameters:
//   ROWS  number of array rows / lanes (>= 1)
//   DW    activation width
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low; clears all state
//   in_bus     activation stream (slave side of act_skew_feeder_if)
//   a_out      skewed activations, lane r = a_out[r*DW +: DW]
//   a_valid    per-lane valid
//   tile_done  one-cycle pulse with the tile's last element on lane ROWS-1
//   busy       feeder is streaming or draining a tile
// ---------------------------------------------------------------------------

// Protocol properties of the feeder's status outputs.
module act_skew_feeder_chk #(
    parameter int ROWS = 2
) (
    input logic clk,
    input logic reset,
    input logic in_ready,
    input logic tile_done,
    input logic busy
);
    // The tile_done cycle is an IDLE cycle: ready and not busy.
    a_done_idle: assert property (@(posedge clk) disable iff (!reset)
        tile_done |-> (in_ready && !busy));

    // The feeder only refuses input while it is draining a tile.
    a_stall_busy: assert property (@(posedge clk) disable iff (!reset)
        !in_ready |-> busy);

    if (ROWS > 1) begin : g_multi
        // A new tile needs at least one drain cycle, so pulses never abut.
        a_done_single: assert property (@(posedge clk) disable iff (!reset)
            tile_done |=> !tile_done);
    end
endmodule

module act_skew_feeder #(
    parameter int ROWS = 2,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               reset,
    act_skew_feeder_if.slave   in_bus,
    output logic [ROWS*DW-1:0] a_out,
    output logic [ROWS-1:0]    a_valid,
    output logic               tile_done,
    output logic               busy
);
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          done_nxt_s;
    logic          in_ready_r;
    logic          busy_r;
    logic          tile_done_r;
    logic          accept_s;

    assign accept_s        = in_bus.in_valid & in_ready_r;
    assign in_bus.in_ready = in_ready_r;
    assign tile_done       = tile_done_r;
    assign busy            = busy_r;

    // Next state, drain counter and tile_done scheduling.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_STREAM: begin
                if (accept_s && in_bus.in_last) begin
                    if (ROWS == 1) begin
                        // Single lane: the last element is already on the
                        // final lane next cycle, so no drain is needed.
                        state_nxt_s = ST_IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                        cnt_nxt_s   = CW'(ROWS - 1);
                    end
                end else if (accept_s) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DRAIN: begin
                cnt_nxt_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    // Last element reaches lane ROWS-1 at this edge.
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, drain counter and registered handshake/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            tile_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_DRAIN);
            busy_r      <= (state_nxt_s != ST_IDLE);
            tile_done_r <= done_nxt_s;
        end
    end

    // Per-lane skew pipelines: lane r has r delay stages plus its output
    // register, all shifting every cycle regardless of accepts.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DW-1:0] data_r [0:r];
        logic          vld_r  [0:r];

        // Lane r pipeline: stage 0 takes the input slot, later stages copy
        // their predecessor; stage r is the lane's output register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s <= r; s++) begin
                    data_r[s] <= {DW{1'b0}};
                    vld_r[s]  <= 1'b0;
                end
            end else begin
                vld_r[0] <= accept_s;
`ifdef SKEW_ZERO_FILL_EN
                data_r[0] <= accept_s ? in_bus.in_data[r*DW +: DW] : {DW{1'b0}};
`else
                if (accept_s) begin
                    data_r[0] <= in_bus.in_data[r*DW +: DW];
                end else begin
                    data_r[0] <= data_r[0];
                end
`endif
                for (int s = 1; s <= r; s++) begin
                    vld_r[s] <= vld_r[s-1];
`ifdef SKEW_ZERO_FILL_EN
                    // Bubbles already carry zero from stage 0.
                    data_r[s] <= data_r[s-1];
`else
                    // Bubbles leave the stage untouched to avoid toggling.
                    if (vld_r[s-1]) begin
                        data_r[s] <= data_r[s-1];
                    end else begin
                        data_r[s] <= data_r[s];
                    end
`endif
                end
            end
        end

        assign a_out[r*DW +: DW] = data_r[r];
        assign a_valid[r]        = vld_r[r];
    end

    act_skew_feeder_chk #(
        .ROWS (ROWS)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .in_ready  (in_ready_r),
        .tile_done (tile_done_r),
        .busy      (busy_r)
    );
endmodule

// File: tb/tb_act_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_act_skew_feeder
//
// Three feeders (ROWS = 1, 2, 4) share one clock and reset. The driver issues
// directed tiles followed by random traffic; for every accepted vector it
// pushes the expected lane arrivals, tile_done cycle and handshake status
// into queues. A negedge monitor pops and compares against what the DUTs
// present. Bubble contents follow the build: zero with SKEW_ZERO_FILL_EN,
// otherwise the last valid value seen on that lane.
// ---------------------------------------------------------------------------
module tb_act_skew_feeder;
    localparam int DW   = 8;
    localparam int NCFG = 3;
    localparam int MAXR = 4;
`ifdef SKEW_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    typedef struct {
        int         stamp;
        logic [7:0] data;
    } ent_t;

    typedef struct {
        int   stamp;
        logic rdy;
        logic bsy;
    } hs_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    logic in_rst = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus per configuration.
    logic       st_v [NCFG];
    logic       st_l [NCFG];
    logic [7:0] st_d [NCFG][MAXR];

    // Reference model state.
    ent_t       lane_q [NCFG][MAXR][$];
    int         td_q   [NCFG][$];
    hs_t        hs_q   [NCFG][$];
    int         last_edge [NCFG];
    logic       open_t    [NCFG];
    logic [7:0] hold_v    [NCFG][MAXR];

    act_skew_feeder_if #(.ROWS(1), .DW(DW)) bus1 ();
    act_skew_feeder_if #(.ROWS(2), .DW(DW)) bus2 ();
    act_skew_feeder_if #(.ROWS(4), .DW(DW)) bus4 ();

    logic [1*DW-1:0] a_out1;
    logic [0:0]      a_valid1;
    logic            td1, busy1;
    logic [2*DW-1:0] a_out2;
    logic [1:0]      a_valid2;
    logic            td2, busy2;
    logic [4*DW-1:0] a_out4;
    logic [3:0]      a_valid4;
    logic            td4, busy4;

    assign bus1.in_valid = st_v[0];
    assign bus1.in_last  = st_l[0];
    assign bus1.in_data  = st_d[0][0];
    assign bus2.in_valid = st_v[1];
    assign bus2.in_last  = st_l[1];
    assign bus2.in_data  = {st_d[1][1], st_d[1][0]};
    assign bus4.in_valid = st_v[2];
    assign bus4.in_last  = st_l[2];
    assign bus4.in_data  = {st_d[2][3], st_d[2][2], st_d[2][1], st_d[2][0]};

    act_skew_feeder #(.ROWS(1), .DW(DW)) dut1 (
        .clk(clk), .reset(reset), .in_bus(bus1),
        .a_out(a_out1), .a_valid(a_valid1), .tile_done(td1), .busy(busy1));
    act_skew_feeder #(.ROWS(2), .DW(DW)) dut2 (
        .clk(clk), .reset(reset), .in_bus(bus2),
        .a_out(a_out2), .a_valid(a_valid2), .tile_done(td2), .busy(busy2));
    act_skew_feeder #(.ROWS(4), .DW(DW)) dut4 (
        .clk(clk), .reset(reset), .in_bus(bus4),
        .a_out(a_out4), .a_valid(a_valid4), .tile_done(td4), .busy(busy4));

    // Uniform view of the three DUTs' outputs.
    logic [7:0] ob_a [NCFG][MAXR];
    logic       ob_v [NCFG][MAXR];
    logic       ob_td [NCFG];
    logic       ob_rdy [NCFG];
    logic       ob_busy [NCFG];

    always_comb begin
        for (int k = 0; k < NCFG; k++) begin
            for (int r = 0; r < MAXR; r++) begin
                ob_a[k][r] = 8'h00;
                ob_v[k][r] = 1'b0;
            end
        end
        ob_a[0][0] = a_out1;
        ob_v[0][0] = a_valid1[0];
        for (int r = 0; r < 2; r++) begin
            ob_a[1][r] = a_out2[r*DW +: DW];
            ob_v[1][r] = a_valid2[r];
        end
        for (int r = 0; r < 4; r++) begin
            ob_a[2][r] = a_out4[r*DW +: DW];
            ob_v[2][r] = a_valid4[r];
        end
        ob_td[0]   = td1;
        ob_td[1]   = td2;
        ob_td[2]   = td4;
        ob_rdy[0]  = bus1.in_ready;
        ob_rdy[1]  = bus2.in_ready;
        ob_rdy[2]  = bus4.in_ready;
        ob_busy[0] = busy1;
        ob_busy[1] = busy2;
        ob_busy[2] = busy4;
    end

    function automatic int rows(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string nm, input int k, input int lane,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s rows=%0d lane=%0d cyc=%0d got=%0h want=%0h",
                     nm, rows(k), lane, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NCFG; k++) begin
            for (int r = 0; r < MAXR; r++) begin
                lane_q[k][r].delete();
                hold_v[k][r] = 8'h00;
            end
            td_q[k].delete();
            hs_q[k].delete();
            last_edge[k] = -100;
            open_t[k]    = 1'b0;
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < NCFG; k++) begin
            st_v[k] = 1'b0;
            st_l[k] = 1'b0;
            for (int r = 0; r < MAXR; r++) st_d[k][r] = 8'h00;
        end
    endtask

    task automatic put(input int k, input logic v, input logic l,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
        st_v[k] = v;
        st_l[k] = l;
        st_d[k][0] = d0;
        st_d[k][1] = d1;
        st_d[k][2] = d2;
        st_d[k][3] = d3;
    endtask

    // Issue the current stimulus at the next edge and record what it implies.
    // Ready rule: after an accepted last at edge E, in_ready is low in the
    // cycles following edges E .. E+R-2.
    task automatic step();
        int   e;
        int   rr;
        logic rdy_now;
        logic rdy_nxt;
        ent_t en;
        hs_t  hs;
        e = cyc + 1;
        for (int k = 0; k < NCFG; k++) begin
            rr      = rows(k);
            rdy_now = ((cyc - last_edge[k]) >= rr - 1);
            if (st_v[k] && rdy_now) begin
                for (int r = 0; r < rr; r++) begin
                    en.stamp = e + r;
                    en.data  = st_d[k][r];
                    lane_q[k][r].push_back(en);
                end
                if (st_l[k]) begin
                    td_q[k].push_back(e + rr - 1);
                    last_edge[k] = e;
                    open_t[k]    = 1'b0;
                end else begin
                    open_t[k] = 1'b1;
                end
            end
            rdy_nxt  = ((e - last_edge[k]) >= rr - 1);
            hs.stamp = e;
            hs.rdy   = rdy_nxt;
            hs.bsy   = open_t[k] || !rdy_nxt;
            hs_q[k].push_back(hs);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int n);
        idle_all();
        repeat (n) step();
    endtask

    // Asynchronous reset: outputs must clear without waiting for an edge.
    task automatic do_reset(input int hold_cycles);
        #1;
        in_rst = 1'b1;
        reset  = 1'b0;
        idle_all();
        #1;
        for (int k = 0; k < NCFG; k++) begin
            chk("rst_in_ready", k, 0, 32'(ob_rdy[k]), 32'd1);
            chk("rst_busy", k, 0, 32'(ob_busy[k]), 32'd0);
            chk("rst_tile_done", k, 0, 32'(ob_td[k]), 32'd0);
            for (int r = 0; r < rows(k); r++) begin
                chk("rst_a_valid", k, r, 32'(ob_v[k][r]), 32'd0);
                chk("rst_a_out", k, r, 32'(ob_a[k][r]), 32'd0);
            end
        end
        clear_model();
        repeat (hold_cycles) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        for (int k = 0; k < NCFG; k++) begin
            chk("post_rst_in_ready", k, 0, 32'(ob_rdy[k]), 32'd1);
        end
        @(posedge clk);
        #1;
        in_rst = 1'b0;
    endtask

    // Monitor: pop and compare whatever the DUTs present this cycle.
    always @(negedge clk) begin : monitor
        logic       ev;
        logic [7:0] ed;
        if (!in_rst) begin
            for (int k = 0; k < NCFG; k++) begin
                for (int r = 0; r < rows(k); r++) begin
                    ev = (lane_q[k][r].size() > 0) && (lane_q[k][r][0].stamp == cyc);
                    chk("a_valid", k, r, 32'(ob_v[k][r]), 32'(ev));
                    if (ev) begin
                        ed = lane_q[k][r][0].data;
                        void'(lane_q[k][r].pop_front());
                        hold_v[k][r] = ed;
                    end else begin
                        ed = ZF ? 8'h00 : hold_v[k][r];
                    end
                    chk("a_out", k, r, 32'(ob_a[k][r]), 32'(ed));
                end
                ev = (td_q[k].size() > 0) && (td_q[k][0] == cyc);
                chk("tile_done", k, 0, 32'(ob_td[k]), 32'(ev));
                if (ev) void'(td_q[k].pop_front());
                if ((hs_q[k].size() > 0) && (hs_q[k][0].stamp == cyc)) begin
                    chk("in_ready", k, 0, 32'(ob_rdy[k]), 32'(hs_q[k][0].rdy));
                    chk("busy", k, 0, 32'(ob_busy[k]), 32'(hs_q[k][0].bsy));
                    void'(hs_q[k].pop_front());
                end
            end
        end
    end

    initial begin
        idle_all();
        clear_model();
        do_reset(2);

        // ROWS=2: {2,7} then {3,1,last}.
        put(1, 1'b1, 1'b0, 8'd2, 8'd7, 8'd0, 8'd0);
        step();
        put(1, 1'b1, 1'b1, 8'd3, 8'd1, 8'd0, 8'd0);
        step();
        run_idle(3);

        // ROWS=2: {5,6}, bubble, {8,9,last}.
        put(1, 1'b1, 1'b0, 8'd5, 8'd6, 8'd0, 8'd0);
        step();
        idle_all();
        step();
        put(1, 1'b1, 1'b1, 8'd8, 8'd9, 8'd0, 8'd0);
        step();
        run_idle(3);

        // ROWS=4: single-vector tile.
        put(2, 1'b1, 1'b1, 8'd1, 8'd2, 8'd3, 8'd4);
        step();
        run_idle(5);

        // ROWS=2: reset while draining; no tile_done may follow.
        put(1, 1'b1, 1'b1, 8'd3, 8'd1, 8'd0, 8'd0);
        step();
        do_reset(2);
        run_idle(3);

        // ROWS=2: vector held during drain is taken in the tile_done cycle.
        put(1, 1'b1, 1'b1, 8'd3, 8'd1, 8'd0, 8'd0);
        step();
        put(1, 1'b1, 1'b0, 8'd4, 8'd4, 8'd0, 8'd0);
        step();
        step();
        run_idle(3);

        // ROWS=1: back-to-back single-vector tiles, then a two-vector tile.
        put(0, 1'b1, 1'b1, 8'd9, 8'd0, 8'd0, 8'd0);
        step();
        put(0, 1'b1, 1'b1, 8'd10, 8'd0, 8'd0, 8'd0);
        step();
        put(0, 1'b1, 1'b0, 8'd11, 8'd0, 8'd0, 8'd0);
        step();
        put(0, 1'b1, 1'b1, 8'd12, 8'd0, 8'd0, 8'd0);
        step();
        run_idle(3);

        // Random traffic on all three feeders with one reset mid-run.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NCFG; k++) begin
                st_v[k] = ($urandom_range(0, 3) != 0);
                st_l[k] = ($urandom_range(0, 4) == 0);
                for (int r = 0; r < MAXR; r++) st_d[k][r] = 8'($urandom);
            end
            step();
            if (i == 200) do_reset(1);
        end
        run_idle(6);

        @(negedge clk);
        #1;
        for (int k = 0; k < NCFG; k++) begin
            chk("tile_done_pending", k, 0, 32'(td_q[k].size()), 32'd0);
            for (int r = 0; r < rows(k); r++) begin
                chk("lane_pending", k, r, 32'(lane_q[k][r].size()), 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
